// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU among NUM_REQ requesters.
// One operation is in flight at a time; results return with a one-hot valid pulse.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0]  req_cmd,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_result,
  output logic                  rsp_err,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [2:0]            alu_cmd,
  input  logic                  alu_ready,
  input  logic                  alu_valid,
  input  logic [31:0]           alu_result
);
  localparam int DATA_W = 32;
  localparam int CMD_W  = 3;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CMD_W-1:0] CMD_NOP = '0;
  localparam logic [IDX_W:0]   N_EXT   = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    own_idx;
  logic [IDX_W-1:0]    gnt_off;
  logic [IDX_W-1:0]    gnt_idx;
  logic [IDX_W:0]      gnt_sum;
  logic                gnt_found;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]  req_rot;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [CNT_W-1:0]    wait_cnt;
  logic                saw_busy;
  logic [DATA_W-1:0]   a_arr   [NUM_REQ];
  logic [DATA_W-1:0]   b_arr   [NUM_REQ];
  logic [CMD_W-1:0]    cmd_arr [NUM_REQ];

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i]   = req_a[DATA_W*i +: DATA_W];
    assign b_arr[i]   = req_b[DATA_W*i +: DATA_W];
    assign cmd_arr[i] = req_cmd[CMD_W*i +: CMD_W];
  end

  // Rotate requests so that bit 0 is the rr_ptr position; the lowest set bit wins.
  assign req_dbl = {req_valid, req_valid} >> rr_ptr;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    gnt_found = 1'b0;
    gnt_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        gnt_found = 1'b1;
        gnt_off   = IDX_W'(k);
      end
    end
  end

  assign gnt_sum = {1'b0, rr_ptr} + {1'b0, gnt_off};
  assign gnt_idx = (gnt_sum >= N_EXT) ? IDX_W'(gnt_sum - N_EXT) : gnt_sum[IDX_W-1:0];

  assign req_ready = (state == S_IDLE && gnt_found && !reset) ? onehot(gnt_idx) : '0;
  assign alu_a     = op_a;
  assign alu_b     = op_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      own_idx    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      alu_cmd    <= CMD_NOP;
      saw_busy   <= 1'b0;
      wait_cnt   <= '0;
      rsp_valid  <= '0;
      rsp_err    <= 1'b0;
      rsp_result <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            op_a    <= a_arr[gnt_idx];
            op_b    <= b_arr[gnt_idx];
            alu_cmd <= cmd_arr[gnt_idx];
            own_idx <= gnt_idx;
            rr_ptr  <= (gnt_idx == LAST) ? '0 : gnt_idx + IDX_W'(1);
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (alu_ready) begin
            saw_busy <= 1'b0;
            wait_cnt <= '0;
            alu_cmd  <= CMD_NOP;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // alu_valid is sticky, so a result only counts after the ALU has been seen busy.
          if (!alu_ready) saw_busy <= 1'b1;
          if (saw_busy && alu_ready && alu_valid) begin
            rsp_result <= alu_result;
            rsp_valid  <= onehot(own_idx);
            state      <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
              rsp_result <= '0;
              rsp_err    <= 1'b1;
              rsp_valid  <= onehot(own_idx);
              state      <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
